dotprod_sequencer: RTL and testbench

Job-level sequencer for the dot-product engine. It owns the SRAM control bus of the three-bank memory: bank 0 holds operand A, bank 1 holds operand B, and bank 2 holds results. For each job it runs an optional clear, then loads both operand vectors from a host stream, then issues paired reads that drive the MAC enables, then writes one result word. It sits between the host/top-level control and the SRAM array plus MAC datapath.

---
 rtl/dotprod_sequencer_if.sv | 45 ++++
 rtl/dotprod_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_dotprod_sequencer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/dotprod_sequencer_if.sv
// dotprod_sequencer_if
//   Groups the host handshake, the three-bank SRAM control bus and the MAC
//   control strobes of the dot-product sequencer.
//   master : host / testbench side (drives start, vec_len, load_valid)
//   slave  : sequencer side (drives everything else)
//   Signals:
//     start, vec_len, load_valid          host -> sequencer
//     load_ready                          sequencer -> host
//     Mem_Clear, En_Chip_Select,
//     En_Write, En_Read                   per-bank strobes, one bit per bank
//     Addr_Read, Addr_Write               packed per-bank addresses,
//                                         bank k at [k*Addr_Width +: Addr_Width]
//     mac_clear, mac_en                   MAC accumulator control
//     busy, done                          job status
interface dotprod_sequencer_if #(
    parameter int Addr_Width = 4,
    parameter int Nums_SRAM  = 3
);
    logic                            start;
    logic [Addr_Width:0]             vec_len;
    logic                            load_valid;
    logic                            load_ready;
    logic [Nums_SRAM-1:0]            Mem_Clear;
    logic [Nums_SRAM-1:0]            En_Chip_Select;
    logic [Nums_SRAM-1:0]            En_Write;
    logic [Nums_SRAM-1:0]            En_Read;
    logic [Nums_SRAM*Addr_Width-1:0] Addr_Read;
    logic [Nums_SRAM*Addr_Width-1:0] Addr_Write;
    logic                            mac_clear;
    logic                            mac_en;
    logic                            busy;
    logic                            done;

    modport master (
        output start, vec_len, load_valid,
        input  load_ready, Mem_Clear, En_Chip_Select, En_Write, En_Read,
               Addr_Read, Addr_Write, mac_clear, mac_en, busy, done
    );

    modport slave (
        input  start, vec_len, load_valid,
        output load_ready, Mem_Clear, En_Chip_Select, En_Write, En_Read,
               Addr_Read, Addr_Write, mac_clear, mac_en, busy, done
    );
endinterface

// File: rtl/dotprod_sequencer.sv
// dotprod_sequencer
//   Job-level sequencer for the dot-product engine. Per job: optional clear
//   of the operand banks, load of operand A (bank 0) and operand B (bank 1)
//   from the host stream, paired reads that drive the MAC enables, then one
//   result write to bank 2 at a wrapping result pointer.
//   Ports:
//     clk      rising-edge clock
//     reset_n  asynchronous active-low reset; every output reads 0 while low
//     bus      dotprod_sequencer_if.slave (host handshake, SRAM bus, MAC ctl)
//   Build option:
//     SEQ_MEM_CLEAR_EN  when defined, a one-cycle CLEAR state pulses
//                       Mem_Clear on banks 0 and 1 before loading; when
//                       undefined, Mem_Clear stays 0 and CLEAR is skipped.
module dotprod_sequencer #(
    parameter int Addr_Width   = 4,
    parameter int Nums_SRAM    = 3,
    parameter int Read_Latency = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    dotprod_sequencer_if.slave bus
);
    localparam int Ram_Depth = 1 << Addr_Width;
    localparam int LW        = Addr_Width + 1;
    localparam int BANK_A    = 0;
    localparam int BANK_B    = 1;
    localparam int BANK_R    = 2;
    localparam logic [LW-1:0] DEPTH_LEN  = LW'(Ram_Depth);
    localparam logic [LW-1:0] DRAIN_LAST = LW'(Read_Latency - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_LOAD_A, S_LOAD_B, S_COMPUTE, S_DRAIN, S_WRITE, S_DONE
    } state_e;

`ifdef SEQ_MEM_CLEAR_EN
    localparam state_e JOB_ENTRY = S_CLEAR;
`else
    localparam state_e JOB_ENTRY = S_LOAD_A;
`endif

    state_e                  state_q, state_d;
    logic [LW-1:0]           len_q, len_d;
    logic [LW-1:0]           idx_q, idx_d;
    logic [Addr_Width-1:0]   res_ptr_q, res_ptr_d;
    logic [Read_Latency-1:0] rd_pipe_q, rd_pipe_d;

    logic [LW-1:0]           idx_inc;
    logic [LW-1:0]           len_clamped;
    logic [Addr_Width-1:0]   idx_addr;
    logic                    last_elem;
    logic                    load_ready_c, mac_clear_c, done_c;
    logic [Nums_SRAM-1:0]    clr_c, we_c, re_c;
    logic [Nums_SRAM*Addr_Width-1:0] ra_c, wa_c;

    assign idx_inc     = idx_q + 1'b1;
    assign idx_addr    = idx_q[Addr_Width-1:0];
    assign last_elem   = (idx_inc == len_q);
    assign len_clamped = (bus.vec_len > DEPTH_LEN) ? DEPTH_LEN : bus.vec_len;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        idx_d        = idx_q;
        res_ptr_d    = res_ptr_q;
        load_ready_c = 1'b0;
        mac_clear_c  = 1'b0;
        done_c       = 1'b0;
        clr_c        = '0;
        we_c         = '0;
        re_c         = '0;
        ra_c         = '0;
        wa_c         = '0;
        // Gating on reset_n keeps the combinational strobes (e.g. mac_clear
        // from start in IDLE) at 0 while reset is held, not just after it.
        if (reset_n) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        len_d = len_clamped;
                        if (len_clamped == '0) begin
                            // Empty job: zero the accumulator so 0 is written.
                            mac_clear_c = 1'b1;
                            state_d     = S_WRITE;
                        end else begin
                            state_d = JOB_ENTRY;
                        end
                    end
                end
                S_CLEAR: begin
`ifdef SEQ_MEM_CLEAR_EN
                    clr_c[BANK_A] = 1'b1;
                    clr_c[BANK_B] = 1'b1;
`endif
                    state_d = S_LOAD_A;
                end
                S_LOAD_A, S_LOAD_B: begin
                    load_ready_c = 1'b1;
                    if (bus.load_valid) begin
                        if (state_q == S_LOAD_A) begin
                            we_c[BANK_A] = 1'b1;
                            wa_c[BANK_A*Addr_Width +: Addr_Width] = idx_addr;
                        end else begin
                            we_c[BANK_B] = 1'b1;
                            wa_c[BANK_B*Addr_Width +: Addr_Width] = idx_addr;
                        end
                        if (last_elem) begin
                            idx_d   = '0;
                            state_d = (state_q == S_LOAD_A) ? S_LOAD_B : S_COMPUTE;
                        end else begin
                            idx_d = idx_inc;
                        end
                    end
                end
                S_COMPUTE: begin
                    re_c[BANK_A] = 1'b1;
                    re_c[BANK_B] = 1'b1;
                    ra_c[BANK_A*Addr_Width +: Addr_Width] = idx_addr;
                    ra_c[BANK_B*Addr_Width +: Addr_Width] = idx_addr;
                    mac_clear_c = (idx_q == '0);
                    if (last_elem) begin
                        idx_d   = '0;
                        state_d = S_DRAIN;
                    end else begin
                        idx_d = idx_inc;
                    end
                end
                S_DRAIN: begin
                    // idx is reused as the drain counter; it is free here.
                    if (idx_q == DRAIN_LAST) begin
                        idx_d   = '0;
                        state_d = S_WRITE;
                    end else begin
                        idx_d = idx_inc;
                    end
                end
                S_WRITE: begin
                    we_c[BANK_R] = 1'b1;
                    wa_c[BANK_R*Addr_Width +: Addr_Width] = res_ptr_q;
                    res_ptr_d = res_ptr_q + 1'b1;
                    state_d   = S_DONE;
                end
                S_DONE: begin
                    done_c  = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // mac_en is the bank-A read strobe aligned to the SRAM read data.
    always_comb begin
        rd_pipe_d    = '0;
        rd_pipe_d[0] = re_c[BANK_A];
        for (int i = 1; i < Read_Latency; i++) begin
            rd_pipe_d[i] = rd_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            idx_q     <= '0;
            res_ptr_q <= '0;
            rd_pipe_q <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            res_ptr_q <= res_ptr_d;
            rd_pipe_q <= rd_pipe_d;
        end
    end

    assign bus.load_ready     = load_ready_c;
    assign bus.Mem_Clear      = clr_c;
    assign bus.En_Write       = we_c;
    assign bus.En_Read        = re_c;
    assign bus.En_Chip_Select = clr_c | we_c | re_c;
    assign bus.Addr_Read      = ra_c;
    assign bus.Addr_Write     = wa_c;
    assign bus.mac_clear      = mac_clear_c;
    assign bus.mac_en         = rd_pipe_q[Read_Latency-1];
    assign bus.busy           = (state_q != S_IDLE);
    assign bus.done           = done_c;
endmodule

// File: tb/tb_dotprod_sequencer.sv
// tb_dotprod_sequencer
//   Self-checking bench for dotprod_sequencer: a vector table of jobs with
//   expected per-bank transfer counts and latencies, hand-written reset
//   sequences, and randomized back-to-back jobs checked against a job-level
//   model (address sequences, counts, result pointer, latency formula).
module tb_dotprod_sequencer;
    localparam int AW    = 4;
    localparam int NB    = 3;
    localparam int RL    = 1;
    localparam int DEPTH = 1 << AW;
`ifdef SEQ_MEM_CLEAR_EN
    localparam int CLR = 1;
`else
    localparam int CLR = 0;
`endif
    localparam int HELD   = 0;
    localparam int TOGGLE = 1;
    localparam int RAND   = 2;

    typedef struct {
        int vlen;
        int mode;
        int exp_lat;
        int exp_n;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    dotprod_sequencer_if #(.Addr_Width(AW), .Nums_SRAM(NB)) bus ();

    dotprod_sequencer #(
        .Addr_Width(AW), .Nums_SRAM(NB), .Read_Latency(RL)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int exp_res = 0;

    logic [NB-1:0]    s_clr, s_cs, s_we, s_re;
    logic [NB*AW-1:0] s_ra, s_wa;
    logic             s_lr, s_mc, s_me, s_busy, s_done, s_lv;
    logic [7:0]       rd_hist = '0;

    int wa0[$], wa1[$], rda[$], resa[$];
    int me_cnt, mc_cnt, mc_k, first_rd, clr_cnt, clr_k;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [40:0] all_outs();
        return {bus.Mem_Clear, bus.En_Chip_Select, bus.En_Write, bus.En_Read,
                bus.Addr_Read, bus.Addr_Write, bus.load_ready, bus.mac_clear,
                bus.mac_en, bus.busy, bus.done};
    endfunction

    function automatic logic [9:0] inv_mask();
        logic [9:0] m;
        m = '0;
        if (s_cs !== (s_re | s_we | s_clr)) m[0] = 1'b1;
        if (s_clr[2]) m[1] = 1'b1;
        for (int b = 0; b < NB; b++) begin
            if (!s_re[b] && s_ra[b*AW +: AW] != '0) m[2] = 1'b1;
            if (!s_we[b] && s_wa[b*AW +: AW] != '0) m[3] = 1'b1;
        end
        if ((s_we[0] | s_we[1]) && !(s_lv && s_lr)) m[4] = 1'b1;
        if (s_re[2] || (s_re[0] && s_lr)) m[5] = 1'b1;
        if ((s_re[0] !== s_re[1]) || (s_re[0] && s_ra[AW-1:0] != s_ra[2*AW-1:AW])) m[6] = 1'b1;
        if (s_me !== rd_hist[RL]) m[7] = 1'b1;
        if (CLR == 0 ? (s_clr != '0) : (s_clr != '0 && s_clr != 3'b011)) m[8] = 1'b1;
        if (!s_busy && ((s_we | s_re | s_clr) != '0 || s_lr || s_done)) m[9] = 1'b1;
        return m;
    endfunction

    // One clock: drive inputs just after the rising edge, sample at the falling edge.
    task automatic cycle(input logic st, input logic lv, input logic [AW:0] vl);
        @(posedge clk);
        #1;
        bus.start      = st;
        bus.load_valid = lv;
        bus.vec_len    = vl;
        @(negedge clk);
        s_clr = bus.Mem_Clear;  s_cs = bus.En_Chip_Select;
        s_we  = bus.En_Write;   s_re = bus.En_Read;
        s_ra  = bus.Addr_Read;  s_wa = bus.Addr_Write;
        s_lr  = bus.load_ready; s_mc = bus.mac_clear; s_me = bus.mac_en;
        s_busy = bus.busy;      s_done = bus.done;    s_lv = bus.load_valid;
        rd_hist = {rd_hist[6:0], s_re[0]};
        check("cycle_invariants", 64'(inv_mask()), 64'd0);
    endtask

    function automatic logic pick_lv(input int mode, input int k);
        if (mode == HELD) return 1'b1;
        if (mode == TOGGLE) return (k % 2) == ((1 + CLR) % 2);
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic record(input int k);
        if (s_we[0]) wa0.push_back(int'(s_wa[AW-1:0]));
        if (s_we[1]) wa1.push_back(int'(s_wa[2*AW-1:AW]));
        if (s_we[2]) resa.push_back(int'(s_wa[3*AW-1:2*AW]));
        if (s_re[0]) begin
            rda.push_back(int'(s_ra[AW-1:0]));
            if (first_rd < 0) first_rd = k;
        end
        if (s_me) me_cnt++;
        if (s_mc) begin mc_cnt++; mc_k = k; end
        if (s_clr != '0) begin clr_cnt++; clr_k = k; end
    endtask

    task automatic check_seq(input string nm, input int q[$], input int n);
        int bad;
        bad = 0;
        check({nm, "_count"}, 64'(q.size()), 64'(n));
        foreach (q[i]) if (q[i] != i) bad++;
        check({nm, "_order"}, 64'(bad), 64'd0);
    endtask

    task automatic run_job(input string nm, input int vlen, input int mode,
                           input int exp_lat, input int exp_n, input bit noise);
        int lat, not_busy;
        bit seen;
        logic st, lv;
        logic [AW:0] vl;
        wa0.delete(); wa1.delete(); rda.delete(); resa.delete();
        me_cnt = 0; mc_cnt = 0; mc_k = -1; first_rd = -1; clr_cnt = 0; clr_k = -1;
        cycle(1'b1, pick_lv(mode, 0), vlen[AW:0]);
        check({nm, "_idle_at_start"}, 64'(s_busy), 64'd0);
        record(0);
        seen = 0; lat = -1; not_busy = 0;
        for (int k = 1; k <= 400; k++) begin
            lv = pick_lv(mode, k);
            st = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            vl = noise ? (AW+1)'($urandom_range(0, 31)) : vlen[AW:0];
            cycle(st, lv, vl);
            record(k);
            if (!s_busy) not_busy++;
            if (s_done) begin seen = 1; lat = k; break; end
        end
        check({nm, "_done_seen"}, 64'(seen), 64'd1);
        if (exp_lat >= 0) check({nm, "_latency"}, 64'(lat), 64'(exp_lat));
        check({nm, "_busy_held"}, 64'(not_busy), 64'd0);
        check_seq({nm, "_wr_a"}, wa0, exp_n);
        check_seq({nm, "_wr_b"}, wa1, exp_n);
        check_seq({nm, "_rd"}, rda, exp_n);
        check({nm, "_mac_en_cnt"}, 64'(me_cnt), 64'(exp_n));
        check({nm, "_mac_clear_cnt"}, 64'(mc_cnt), 64'd1);
        if (exp_n > 0) check({nm, "_mac_clear_first_rd"}, 64'(mc_k), 64'(first_rd));
        check({nm, "_res_writes"}, 64'(resa.size()), 64'd1);
        check({nm, "_res_addr"}, 64'(resa.size() > 0 ? resa[0] : 99), 64'(exp_res));
        check({nm, "_clear_cnt"}, 64'(clr_cnt), 64'(exp_n > 0 ? CLR : 0));
        check({nm, "_clear_cycle"}, 64'(clr_k), 64'((exp_n > 0 && CLR == 1) ? 1 : -1));
        exp_res = (exp_res + 1) % DEPTH;
    endtask

    function automatic int model_lat(input int n, input int mode);
        if (mode != HELD) return -1;
        if (n == 0) return 2;
        return CLR + 3 * n + RL + 2;
    endfunction

    vec_t tbl[7];

    initial begin
        int n, mode, v;
        tbl[0] = '{4,  HELD,   15 + CLR, 4};
        tbl[1] = '{1,  HELD,    6 + CLR, 1};
        tbl[2] = '{0,  HELD,    2,       0};
        tbl[3] = '{20, HELD,   51 + CLR, 16};
        tbl[4] = '{3,  TOGGLE, -1,       3};
        tbl[5] = '{16, HELD,   51 + CLR, 16};
        tbl[6] = '{2,  HELD,    9 + CLR, 2};

        // Reset held with an active-looking host: outputs must stay 0.
        reset_n        = 1'b0;
        bus.start      = 1'b1;
        bus.vec_len    = '0;
        bus.load_valid = 1'b1;
        #3;
        check("reset_outs_pre_edge", 64'(all_outs()), 64'd0);
        #4;
        check("reset_outs_post_edge", 64'(all_outs()), 64'd0);
        @(negedge clk);
        reset_n   = 1'b1;
        bus.start = 1'b0;
        bus.load_valid = 1'b0;

        foreach (tbl[i])
            run_job($sformatf("tbl%0d", i), tbl[i].vlen, tbl[i].mode,
                    tbl[i].exp_lat, tbl[i].exp_n, 1'b0);

        // Reset in the middle of COMPUTE discards the job and the result pointer.
        cycle(1'b1, 1'b1, 5'd4);
        for (int k = 0; k < 60; k++) begin
            cycle(1'b0, 1'b1, 5'd4);
            if (s_re[0]) break;
        end
        check("reach_compute", 64'(s_re[0]), 64'd1);
        #2;
        bus.start   = 1'b1;
        bus.vec_len = '0;
        reset_n     = 1'b0;
        #1;
        check("midjob_reset_outs", 64'(all_outs()), 64'd0);
        @(negedge clk);
        check("midjob_reset_hold", 64'(all_outs()), 64'd0);
        reset_n        = 1'b1;
        bus.start      = 1'b0;
        bus.load_valid = 1'b0;
        rd_hist        = '0;
        exp_res        = 0;
        cycle(1'b0, 1'b0, 5'd0);
        check("post_reset_busy", 64'(s_busy), 64'd0);
        run_job("after_reset", 4, HELD, 15 + CLR, 4, 1'b0);

        // Random back-to-back jobs with start/vec_len noise while busy.
        for (int j = 0; j < 17; j++) begin
            v    = $urandom_range(0, 20);
            n    = (v > DEPTH) ? DEPTH : v;
            mode = ($urandom_range(0, 1) == 0) ? HELD : RAND;
            run_job($sformatf("rnd%0d", j), v, mode, model_lat(n, mode), n, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
